dfm_spi_master: RTL
===================

DFM_SPI_MASTER -- requirements
Module: dfm_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk_i cycles; legal range 2..255.
REQ-002 SHALL have parameter N_BYTES, default 8: data bytes read per transaction; legal range 1..8.
REQ-003 clk_i  in  1  the single clock for all logic.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  request a transaction; sampled only in IDLE.
REQ-006 cmd_i  in  8  command/register byte; captured when start_i is accepted.
REQ-007 spi_miso_i  in  1  serial data from the meter.
REQ-008 spi_sclk_o  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 spi_mosi_o  out  1  serial command data, MSB first.
REQ-010 spi_cs_n_o  out  1  chip select, active low.
REQ-011 dc_o  out  1  0 = command byte, 1 = data bytes.
REQ-012 busy_o  out  1  high from the cycle after start is accepted until the done_o cycle, inclusive.
REQ-013 done_o  out  1  one-cycle pulse at transaction end.
REQ-014 rd_data_o  out  64  received data, right-aligned; first byte received is most significant; updated only in the done_o cycle.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> CMD -> READ -> HOLD -> IDLE; every output SHALL be registered.
REQ-016 IDLE: cs_n=1, sclk=0, mosi=0, dc=0; start_i=1 loads cmd_i and moves to SETUP next cycle.
REQ-017 SETUP: cs_n=0, dc=0, mosi=cmd[7], sclk=0 for CLK_DIV cycles.
REQ-018 Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; spi_miso_i is sampled on the sclk rising edge; mosi changes only on the sclk falling edge.
REQ-019 CMD: 8 bits of cmd, MSB first, dc=0; READ then starts with dc=1 and mosi=0.
REQ-020 READ: N_BYTES*8 bits shifted in MSB first.
REQ-021 HOLD: sclk=0 and cs_n=0 for CLK_DIV cycles, then cs_n=1, done_o=1, rd_data_o updated, return to IDLE, all in the same cycle.
REQ-022 Bits not received when N_BYTES<8 SHALL read as 0 in rd_data_o.
REQ-023 Total time from the start_i sampling edge to done_o SHALL be 1 + CLK_DIV*(2 + 16*(1+N_BYTES)) cycles (gap feature off).
REQ-024 start_i while busy_o=1 SHALL be ignored; start_i in the done_o cycle SHALL be ignored.
REQ-025 Bit, byte and divider counters SHALL wrap or clear only at phase boundaries; no counter overflow at maximum parameter values.

Reset
REQ-026 rst_i=1 at any clock edge, including mid-transaction, SHALL force IDLE with cs_n=1, sclk=0, mosi=0, dc=0, busy=0, done=0, rd_data_o=0 and all counters 0.
REQ-027 An aborted transaction SHALL NOT produce done_o or change rd_data_o after reset deasserts.

Configuration
REQ-028 Macro DFM_SPI_BYTE_GAP_EN defined: after every byte except the last, sclk SHALL stay low for an extra CLK_DIV cycles with cs_n held low and mosi/dc stable; total time increases by CLK_DIV*N_BYTES cycles.
REQ-029 Macro undefined: bytes SHALL be back-to-back with no gap logic present.

Verification
REQ-030 CLK_DIV=2, N_BYTES=8, cmd 0xA5, slave model returns 0x0123456789ABCDEF -> mosi shows 0xA5 with dc=0, rd_data_o=0x0123456789ABCDEF, done_o exactly 293 cycles after the start edge.
REQ-031 N_BYTES=3, slave returns 0xDE,0xAD,0xBE -> rd_data_o=0x0000000000DEADBE.
REQ-032 start_i pulsed at cycles 5, 50 and in the done_o cycle -> exactly one transaction and one done_o pulse.
REQ-033 rst_i asserted during bit 3 of READ -> outputs at reset values next cycle; no done_o; rd_data_o=0.
REQ-034 DFM_SPI_BYTE_GAP_EN defined, CLK_DIV=2, N_BYTES=8 -> 8 gaps of 2 low-sclk cycles each; done_o at 309 cycles; data still correct.
REQ-035 CLK_DIV=255, N_BYTES=8 -> sclk half-period 255 cycles, no counter wrap errors, done_o at 1+255*146 = 37231 cycles.

Source files
------------

// File: rtl/dfm_spi_master_if.sv
// Host-side request/response bundle for dfm_spi_master.
// The "master" modport is the requesting host; the "slave" modport is the
// SPI controller that serves the request and returns the read data.
interface dfm_spi_master_if;
  logic        start_i;
  logic [7:0]  cmd_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] rd_data_o;

  modport master (
    output start_i,
    output cmd_i,
    input  busy_o,
    input  done_o,
    input  rd_data_o
  );

  modport slave (
    input  start_i,
    input  cmd_i,
    output busy_o,
    output done_o,
    output rd_data_o
  );
endinterface

// File: rtl/dfm_spi_master.sv
// dfm_spi_master: SPI mode-0 reader for a metering device.
// A transaction sends one command byte (dc=0), then clocks in N_BYTES data
// bytes (dc=1), MSB first, and presents them right-aligned on rd_data_o.
// Optional macro DFM_SPI_BYTE_GAP_EN: stretches the sclk-low phase of the
// first bit of every data byte by CLK_DIV cycles, which places one gap after
// each byte except the last (command byte included).
// All pin and handshake outputs come straight from flops; they are computed
// from the current FSM/counter state, so they trail the state by one cycle.
module dfm_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int N_BYTES = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dfm_spi_master_if.slave bus,
  input  logic            spi_miso_i,
  output logic            spi_sclk_o,
  output logic            spi_mosi_o,
  output logic            spi_cs_n_o,
  output logic            dc_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_CMD   = 3'd2,
    S_READ  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] RD_LAST  = 7'(N_BYTES * 8 - 1);

  state_t      r_state, w_state_nx;
  logic [7:0]  r_div,   w_div_nx;    // cycles within the current half/phase
  logic        r_half,  w_half_nx;   // 0 = sclk low half, 1 = sclk high half
  logic [6:0]  r_bit,   w_bit_nx;    // bit index within CMD or READ
  logic [7:0]  r_cmd,   w_cmd_nx;    // command shifter; empties to zeros
  logic [63:0] r_shift, w_shift_nx;  // received bits, shifted in at LSB
`ifdef DFM_SPI_BYTE_GAP_EN
  logic        r_gap,   w_gap_nx;    // extra low interval already spent
`endif

  logic        r_sclk, r_mosi, r_cs_n, r_dc, r_busy, r_done;
  logic [63:0] r_rd_data;
  logic        w_sclk_nx, w_mosi_nx, w_cs_n_nx, w_dc_nx, w_busy_nx, w_done_nx;
  logic        w_div_last;

  assign w_div_last = (r_div == DIV_LAST);

  // Next-state, counter and shifter logic for the transaction sequencer.
  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div;
    w_half_nx  = r_half;
    w_bit_nx   = r_bit;
    w_cmd_nx   = r_cmd;
    w_shift_nx = r_shift;
`ifdef DFM_SPI_BYTE_GAP_EN
    w_gap_nx   = r_gap;
`endif
    case (r_state)
      S_IDLE: begin
        w_div_nx  = 8'd0;
        w_half_nx = 1'b0;
        w_bit_nx  = 7'd0;
        // r_busy still high means this is the done cycle: ignore start.
        if (bus.start_i && !r_busy) begin
          w_state_nx = S_SETUP;
          w_cmd_nx   = bus.cmd_i;
          w_shift_nx = 64'd0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_SETUP, S_HOLD: begin
        if (w_div_last) begin
          w_div_nx   = 8'd0;
          w_state_nx = (r_state == S_SETUP) ? S_CMD : S_IDLE;
        end else begin
          w_div_nx   = r_div + 8'd1;
        end
      end
      S_CMD, S_READ: begin
        // First cycle of the high half is the cycle sclk_o rises.
        if (r_state == S_READ && r_half && r_div == 8'd0) begin
          w_shift_nx = {r_shift[62:0], spi_miso_i};
        end else begin
          w_shift_nx = r_shift;
        end
        if (!w_div_last) begin
          w_div_nx = r_div + 8'd1;
        end else if (!r_half) begin
          w_div_nx = 8'd0;
`ifdef DFM_SPI_BYTE_GAP_EN
          if (r_state == S_READ && r_bit[2:0] == 3'd0 && !r_gap) begin
            w_gap_nx = 1'b1;
          end else begin
            w_gap_nx  = 1'b0;
            w_half_nx = 1'b1;
          end
`else
          w_half_nx = 1'b1;
`endif
        end else begin
          // End of the high half: sclk falls and the next mosi bit appears.
          w_div_nx  = 8'd0;
          w_half_nx = 1'b0;
          w_cmd_nx  = {r_cmd[6:0], 1'b0};
          if (r_state == S_CMD) begin
            if (r_bit == 7'd7) begin
              w_bit_nx   = 7'd0;
              w_state_nx = S_READ;
            end else begin
              w_bit_nx   = r_bit + 7'd1;
            end
          end else begin
            if (r_bit == RD_LAST) begin
              w_bit_nx   = 7'd0;
              w_state_nx = S_HOLD;
            end else begin
              w_bit_nx   = r_bit + 7'd1;
            end
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_div_nx   = 8'd0;
        w_half_nx  = 1'b0;
        w_bit_nx   = 7'd0;
      end
    endcase
  end

  // Pin and handshake values derived from the current sequencer state.
  always_comb begin
    w_sclk_nx = (r_state == S_CMD || r_state == S_READ) && r_half;
    w_mosi_nx = (r_state == S_IDLE) ? 1'b0 : r_cmd[7];
    w_cs_n_nx = (r_state == S_IDLE);
    w_dc_nx   = (r_state == S_READ || r_state == S_HOLD);
    // Done fires once, in the first IDLE cycle after a completed transfer.
    w_done_nx = (r_state == S_IDLE) && r_busy && !r_done;
    w_busy_nx = (r_state != S_IDLE) || w_done_nx;
  end

  // Sequencer state, counters and shifters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_div   <= 8'd0;
      r_half  <= 1'b0;
      r_bit   <= 7'd0;
      r_cmd   <= 8'd0;
      r_shift <= 64'd0;
`ifdef DFM_SPI_BYTE_GAP_EN
      r_gap   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_div   <= w_div_nx;
      r_half  <= w_half_nx;
      r_bit   <= w_bit_nx;
      r_cmd   <= w_cmd_nx;
      r_shift <= w_shift_nx;
`ifdef DFM_SPI_BYTE_GAP_EN
      r_gap   <= w_gap_nx;
`endif
    end
  end

  // Output flops; read data is loaded only together with done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_dc      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= 64'd0;
    end else begin
      r_sclk    <= w_sclk_nx;
      r_mosi    <= w_mosi_nx;
      r_cs_n    <= w_cs_n_nx;
      r_dc      <= w_dc_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_rd_data <= w_done_nx ? r_shift : r_rd_data;
    end
  end

  assign spi_sclk_o    = r_sclk;
  assign spi_mosi_o    = r_mosi;
  assign spi_cs_n_o    = r_cs_n;
  assign dc_o          = r_dc;
  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.rd_data_o = r_rd_data;

endmodule
